pw_digit_entry: RTL and testbench

- Front-end stage for the password FSM. It turns a raw pushbutton and a raw BITS-wide digit switch bank into clean, one-clock digit-entry strobes.
- Its digit_valid output drives the FSM's enable_data input, and its digit output drives entrada_pw.
- It synchronises and debounces the button, latches the digit on each accepted press, and tracks how many digits have been entered. A partial sequence is abandoned after an inactivity timeout.

---
 rtl/pw_digit_entry.sv | 142 ++++++++++++++
 tb/tb_pw_digit_entry.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pw_digit_entry.sv
// Password keypad front end: 2-FF sync, debounced button, one-clock digit strobe, per-sequence count and idle abort.
// Latency: strobe DEBOUNCE_CYCLES+2 clocks after btn_raw rises; all outputs registered; no backpressure (strobe is fire-and-forget).
module pw_digit_entry #(
    parameter int BITS            = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20,
    parameter int TIMEOUT_CYCLES  = 250000000,
    parameter int TO_W            = 28
) (
    input  logic            clk,
    input  logic            rst_a,
    input  logic            btn_raw,
    input  logic [BITS-1:0] sw_raw,
    output logic            digit_valid,
    output logic [BITS-1:0] digit,
    output logic            btn_level,
    output logic [2:0]      entry_count,
    output logic            entry_timeout
);

    localparam logic [1:0] S_LOW  = 2'd0;
    localparam logic [1:0] S_RISE = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_FALL = 2'd3;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    // The timer is cleared on the very edge it would reach TIMEOUT_CYCLES-1, so the last stored value is one below.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

    logic            r_btn_m, r_btn_s;
    logic [BITS-1:0] r_sw_m, r_sw_s;
    logic [1:0]      r_state;
    logic [DB_W-1:0] r_cnt;
    logic [TO_W-1:0] r_timer;
    logic            r_digit_valid;
    logic [BITS-1:0] r_digit;
    logic            r_btn_level;
    logic [2:0]      r_entry_count;
    logic            r_entry_timeout;

    logic [1:0]      w_state_nxt;
    logic [DB_W-1:0] w_cnt_nxt;
    logic            w_press;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        case (r_state)
            S_LOW: begin
                if (r_btn_s) begin
                    w_state_nxt = S_RISE;
                    w_cnt_nxt   = DB_W'(1);
                end
            end
            S_RISE: begin
                if (!r_btn_s) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                    w_press     = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + DB_W'(1);
                end
            end
            S_HIGH: begin
                if (!r_btn_s) begin
                    w_state_nxt = S_FALL;
                    w_cnt_nxt   = DB_W'(1);
                end
            end
            S_FALL: begin
                if (r_btn_s) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + DB_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            r_btn_m         <= 1'b0;
            r_btn_s         <= 1'b0;
            r_sw_m          <= '0;
            r_sw_s          <= '0;
            r_state         <= S_LOW;
            r_cnt           <= '0;
            r_timer         <= '0;
            r_digit_valid   <= 1'b0;
            r_digit         <= '0;
            r_btn_level     <= 1'b0;
            r_entry_count   <= 3'd0;
            r_entry_timeout <= 1'b0;
        end else begin
            r_btn_m       <= btn_raw;
            r_btn_s       <= r_btn_m;
            r_sw_m        <= sw_raw;
            r_sw_s        <= r_sw_m;
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_btn_level   <= (w_state_nxt == S_HIGH) || (w_state_nxt == S_FALL);
            r_digit_valid <= w_press;
            if (w_press) begin
                r_digit <= r_sw_s;
            end

            // A strobe outranks an expiring timer: the digit extends the sequence instead of being lost.
            r_entry_timeout <= 1'b0;
            if (r_digit_valid) begin
                r_entry_count <= (r_entry_count == 3'd4) ? 3'd1 : r_entry_count + 3'd1;
                r_timer       <= '0;
            end else if (r_entry_count == 3'd0) begin
                r_timer       <= '0;
            end else if (r_timer == TO_LAST) begin
                r_entry_timeout <= 1'b1;
                r_entry_count   <= 3'd0;
                r_timer         <= '0;
            end else begin
                r_timer <= r_timer + TO_W'(1);
            end
        end
    end

    assign digit_valid   = r_digit_valid;
    assign digit         = r_digit;
    assign btn_level     = r_btn_level;
    assign entry_count   = r_entry_count;
    assign entry_timeout = r_entry_timeout;

endmodule

// File: tb/tb_pw_digit_entry.sv
// Bench for pw_digit_entry: directed keypad scenarios then random button/switch traffic against a run-length reference model.
module tb_pw_digit_entry;

    localparam int DB = 4;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       btn_raw;
    logic [3:0] sw_raw;
    logic       digit_valid;
    logic [3:0] digit;
    logic       btn_level;
    logic [2:0] entry_count;
    logic       entry_timeout;

    pw_digit_entry #(
        .BITS(4), .DEBOUNCE_CYCLES(DB), .DB_W(3), .TIMEOUT_CYCLES(TO), .TO_W(5)
    ) dut (
        .clk(clk), .rst_a(rst_a), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .digit_valid(digit_valid), .digit(digit), .btn_level(btn_level),
        .entry_count(entry_count), .entry_timeout(entry_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: values of each output after the current edge.
    int         e;
    logic       m_s1, m_s2;
    logic [3:0] m_sw1, m_sw2;
    logic       m_level;
    int         m_run;
    logic       m_dv;
    logic [3:0] m_digit;
    int         m_count;
    logic       m_to;
    int         m_last;

    // Observations of the DUT for scenario-level checks.
    int   obs_dv, obs_to, first_dv_edge, to_edge, drop_edge;
    logic seen_level, prev_level;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, obs, exp, e, $time);
        end
    endtask

    task automatic model_reset;
        e = 0; m_s1 = 0; m_s2 = 0; m_sw1 = 0; m_sw2 = 0;
        m_level = 0; m_run = 0; m_dv = 0; m_digit = 0;
        m_count = 0; m_to = 0; m_last = 0;
    endtask

    task automatic clear_obs;
        obs_dv = 0; obs_to = 0; first_dv_edge = 0; to_edge = 0; drop_edge = 0;
        seen_level = 0; prev_level = btn_level;
    endtask

    task automatic model_edge(input logic b, input logic [3:0] s);
        logic       bs;
        logic [3:0] ss;
        logic       new_dv;
        bs = m_s2; ss = m_sw2; new_dv = 0;
        e++;
        m_s2 = m_s1; m_s1 = b; m_sw2 = m_sw1; m_sw1 = s;
        // Level flips once the synced button has disagreed with it for DB consecutive samples.
        if (bs != m_level) begin
            m_run++;
            if (m_run == DB) begin
                m_level = bs;
                m_run = 0;
                if (bs) begin
                    new_dv = 1;
                    m_digit = ss;
                end
            end
        end else begin
            m_run = 0;
        end
        m_to = 0;
        if (m_dv) begin
            m_count = (m_count == 4) ? 1 : m_count + 1;
        end else if (m_count != 0 && e - m_last == TO) begin
            m_to = 1;
            m_count = 0;
        end
        m_dv = new_dv;
        if (new_dv) m_last = e;
    endtask

    task automatic check_outputs;
        chk("digit_valid", 32'(digit_valid), 32'(m_dv));
        chk("digit", 32'(digit), 32'(m_digit));
        chk("btn_level", 32'(btn_level), 32'(m_level));
        chk("entry_count", 32'(entry_count), 32'(m_count));
        chk("entry_timeout", 32'(entry_timeout), 32'(m_to));
        if (digit_valid) begin
            obs_dv++;
            if (first_dv_edge == 0) first_dv_edge = e;
        end
        if (entry_timeout) begin
            obs_to++;
            to_edge = e;
        end
        if (btn_level) seen_level = 1;
        if (prev_level && !btn_level) drop_edge = e;
        prev_level = btn_level;
    endtask

    task automatic step(input logic b, input logic [3:0] s);
        btn_raw = b;
        sw_raw  = s;
        @(posedge clk);
        model_edge(b, s);
        #1;
        check_outputs();
    endtask

    // Called just after a rising edge; asserts reset mid-cycle and checks outputs before any edge.
    task automatic async_reset(input int hold);
        #2 rst_a = 1'b1;
        model_reset();
        #1 check_outputs();
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 check_outputs();
        end
        rst_a = 1'b0;
        clear_obs();
    endtask

    initial begin
        btn_raw = 0;
        sw_raw  = 0;
        rst_a   = 1;
        model_reset();
        #1 check_outputs();
        @(posedge clk);
        #1 rst_a = 0;
        clear_obs();

        // Clean press of 6, then release.
        repeat (10) step(1, 4'd6);
        chk("press_edge", 32'(first_dv_edge), 32'd6);
        repeat (10) step(0, 4'd6);
        chk("press_strobes", 32'(obs_dv), 32'd1);
        chk("release_edge", 32'(drop_edge), 32'd16);

        // Bounce never qualifies.
        async_reset(0);
        step(1, 4'd5); step(1, 4'd5); step(0, 4'd5);
        step(1, 4'd5); step(1, 4'd5); step(0, 4'd5);
        repeat (10) step(0, 4'd5);
        chk("bounce_strobes", 32'(obs_dv), 32'd0);
        chk("bounce_level", 32'(seen_level), 32'd0);

        // Four-digit sequence then a fifth digit starting a new one.
        async_reset(1);
        begin
            logic [3:0] seq [5];
            seq = '{4'd6, 4'd9, 4'd8, 4'd7, 4'd2};
            for (int i = 0; i < 5; i++) begin
                repeat (8) step(1, seq[i]);
                repeat (5) step(0, seq[i]);
            end
        end
        chk("seq_strobes", 32'(obs_dv), 32'd5);
        chk("seq_timeouts", 32'(obs_to), 32'd0);

        // Single digit then idle: one abort 20 clocks after the strobe.
        async_reset(0);
        repeat (8) step(1, 4'd3);
        repeat (60) step(0, 4'd3);
        chk("timeout_edge", 32'(to_edge), 32'd26);
        chk("timeout_pulses", 32'(obs_to), 32'd1);

        // Second strobe collides with expiry; only the restarted timer fires.
        async_reset(0);
        repeat (8) step(1, 4'd3);
        repeat (11) step(0, 4'd3);
        repeat (8) step(1, 4'd5);
        repeat (30) step(0, 4'd5);
        chk("race_pulses", 32'(obs_to), 32'd1);
        chk("race_edge", 32'(to_edge), 32'd45);

        // Reset during RISE_WAIT with the button held.
        async_reset(0);
        repeat (4) step(1, 4'd6);
        async_reset(0);
        repeat (10) step(1, 4'd6);
        chk("rst_rise_edge", 32'(first_dv_edge), 32'd6);
        chk("rst_rise_strobes", 32'(obs_dv), 32'd1);

        // Reset with two digits entered, button held through release.
        async_reset(0);
        repeat (2) begin
            repeat (8) step(1, 4'd4);
            repeat (5) step(0, 4'd4);
        end
        repeat (3) step(1, 4'd6);
        async_reset(2);
        repeat (10) step(1, 4'd6);
        chk("rst_seq_edge", 32'(first_dv_edge), 32'd6);
        chk("rst_seq_count", 32'(entry_count), 32'd1);
        repeat (6) step(0, 4'd6);

        // Random traffic.
        for (int r = 0; r < 400; r++) begin
            logic       b;
            logic [3:0] s;
            int         len;
            if ($urandom_range(0, 39) == 0) async_reset(int'($urandom_range(0, 2)));
            b   = 1'($urandom_range(0, 1));
            s   = 4'($urandom);
            len = int'($urandom_range(1, 12));
            if (!b && $urandom_range(0, 3) == 0) len = int'($urandom_range(15, 30));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 5) == 0) s = 4'($urandom);
                step(b, s);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
